// File: rtl/apb_nslv_bridge.sv
// AHB-Lite to APB3 bridge for NSLV peripheral slaves: single 32-bit transfers,
// PREADY wait states, PSLVERR/decode/timeout errors and fully registered outputs.
module apb_nslv_bridge #(
    parameter int NSLV    = 8,
    parameter int ADDR_W  = 40,
    parameter int SLV_AW  = 12,
    parameter int TMO_CYC = 255
) (
    input  logic              hclk,
    input  logic              hrst_b,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    output logic [31:0]       hrdata,
    output logic              hready,
    output logic [1:0]        hresp,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic              penable,
    output logic [NSLV-1:0]   psel,
    input  logic [NSLV*32-1:0] prdata,
    input  logic [NSLV-1:0]   pready,
    input  logic [NSLV-1:0]   pslverr
);
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [IW:0] NSLV_W = (IW + 1)'(NSLV);
    localparam logic [15:0] TMO_W = 16'(TMO_CYC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    state_t         state_r, state_next_s;
    logic [IW-1:0]  idx_r, addr_idx_s;
    logic           dec_err_r, dec_err_s, misalign_s;
    logic [15:0]    wait_cnt_r, wait_inc_s;
    logic           accept_s, timeout_s;
    logic           sel_ready_s, sel_err_s;
    logic [31:0]    sel_rdata_s;
    logic           hready_next_s, apb_sel_next_s, penable_next_s;
    logic [1:0]     hresp_next_s;
    logic           htrans_unused_s;

    function automatic logic [NSLV-1:0] onehot(input logic [IW-1:0] idx);
        logic [NSLV-1:0] v;
        for (int k = 0; k < NSLV; k++) begin
            v[k] = (idx == IW'(k));
        end
        return v;
    endfunction

    assign htrans_unused_s = htrans[0];
    assign addr_idx_s      = haddr[SLV_AW+IW-1:SLV_AW];
    assign wait_inc_s      = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : wait_cnt_r + 16'd1;
    assign timeout_s       = (TMO_W != 16'd0) && (wait_inc_s >= TMO_W);

    // Address-phase decode: unmapped slave, oversized or misaligned transfer
    always_comb begin
        misalign_s = 1'b1;
        case (hsize)
            3'd0:    misalign_s = 1'b0;
            3'd1:    misalign_s = haddr[0];
            3'd2:    misalign_s = |haddr[1:0];
            default: misalign_s = 1'b1;
        endcase
        dec_err_s = misalign_s | ({1'b0, addr_idx_s} >= NSLV_W);
    end

    // AND-OR select of the addressed slave's response; other slaves are ignored
    always_comb begin
        sel_ready_s = 1'b0;
        sel_err_s   = 1'b0;
        sel_rdata_s = 32'h0000_0000;
        for (int k = 0; k < NSLV; k++) begin
            sel_ready_s = sel_ready_s | (pready[k] & (idx_r == IW'(k)));
            sel_err_s   = sel_err_s | (pslverr[k] & (idx_r == IW'(k)));
            sel_rdata_s = sel_rdata_s | (prdata[32*k +: 32] & {32{idx_r == IW'(k)}});
        end
    end

    // Next-state logic and accept qualification
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_RESP, ST_ERR2: begin
                accept_s = hsel & htrans[1] & hready;
                if (accept_s) state_next_s = ST_LATCH;
                else          state_next_s = ST_IDLE;
            end
            ST_LATCH: begin
                if (dec_err_r) state_next_s = ST_ERR1;
                else           state_next_s = ST_SETUP;
            end
            ST_SETUP: state_next_s = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready_s) begin
                    if (sel_err_s) state_next_s = ST_ERR1;
                    else           state_next_s = ST_RESP;
                end else if (timeout_s) begin
                    state_next_s = ST_ERR1;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_ERR1: state_next_s = ST_ERR2;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output values for the coming state, registered below so nothing is combinational
    always_comb begin
        hready_next_s  = 1'b0;
        hresp_next_s   = 2'b00;
        apb_sel_next_s = 1'b0;
        penable_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE, ST_RESP: hready_next_s = 1'b1;
            ST_SETUP:         apb_sel_next_s = 1'b1;
            ST_ACCESS: begin
                apb_sel_next_s = 1'b1;
                penable_next_s = 1'b1;
            end
            ST_ERR1: hresp_next_s = 2'b01;
            ST_ERR2: begin
                hready_next_s = 1'b1;
                hresp_next_s  = 2'b01;
            end
            default: hready_next_s = 1'b0;
        endcase
    end

    // State, latched decode and saturating wait counter
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IW{1'b0}};
            dec_err_r  <= 1'b0;
            wait_cnt_r <= 16'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                idx_r     <= addr_idx_s;
                dec_err_r <= dec_err_s;
            end
            if (state_next_s == ST_SETUP) begin
                wait_cnt_r <= 16'd0;
            end else if ((state_r == ST_ACCESS) && !sel_ready_s) begin
                wait_cnt_r <= wait_inc_s;
            end
        end
    end

    // Registered AHB and APB outputs
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            hready  <= 1'b1;
            hresp   <= 2'b00;
            hrdata  <= 32'h0000_0000;
            psel    <= {NSLV{1'b0}};
            penable <= 1'b0;
            paddr   <= {ADDR_W{1'b0}};
            pwrite  <= 1'b0;
            pwdata  <= 32'h0000_0000;
        end else begin
            hready  <= hready_next_s;
            hresp   <= hresp_next_s;
            psel    <= apb_sel_next_s ? onehot(idx_r) : {NSLV{1'b0}};
            penable <= penable_next_s;
            if (accept_s) begin
                paddr  <= haddr;
                pwrite <= hwrite;
            end
            if ((state_r == ST_LATCH) && pwrite) begin
                pwdata <= hwdata;
            end
            if ((state_r == ST_ACCESS) && sel_ready_s && !sel_err_s && !pwrite) begin
                hrdata <= sel_rdata_s;
            end
        end
    end
endmodule
